display_page_controller: RTL and testbench

//  Top-level screen sequencer for the Morse VGA game. Picks the visible page (START, LEVEL, RESULT)

---
 rtl/display_page_controller_pkg.sv | 35 +++
 rtl/display_page_controller_if.sv | 32 +++
 rtl/switch_frame_debounce.sv | 48 ++++
 rtl/display_page_controller.sv | 132 +++++++++++++
 tb/tb_display_page_controller.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_page_controller_pkg.sv
// Page codes, bus widths, switch layout and level decode for the Morse VGA screen sequencer.
// Definitions only: no state, no latency, no flow control.
package display_page_controller_pkg;
  localparam int PAGE_W    = 2;
  localparam int RGB_W     = 12;
  localparam int LEVEL_CNT = 3;
  localparam int LEVEL_W   = 2;
  localparam int SW_W      = LEVEL_CNT + 1;

  localparam logic [PAGE_W-1:0] PAGE_START  = 2'd0;
  localparam logic [PAGE_W-1:0] PAGE_LEVEL  = 2'd1;
  localparam logic [PAGE_W-1:0] PAGE_RESULT = 2'd2;

  // State encoding doubles as the displayed page code.
  typedef enum logic [PAGE_W-1:0] {
    ST_START  = PAGE_START,
    ST_LEVEL  = PAGE_LEVEL,
    ST_RESULT = PAGE_RESULT
  } state_t;

  typedef struct packed {
    logic                 esc;
    logic [LEVEL_CNT-1:0] lvl;
  } sw_t;

  // One-hot level switch to level number 1..3; anything else decodes to 0.
  function automatic logic [LEVEL_W-1:0] level_index(input logic [LEVEL_CNT-1:0] lvl);
    case (lvl)
      3'b001:  level_index = 2'd1;
      3'b010:  level_index = 2'd2;
      3'b100:  level_index = 2'd3;
      default: level_index = 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/display_page_controller_if.sv
// Switch, game-pulse and pixel bundle between the VGA timing/page generators and the page controller.
// Plain wires: no latency, no flow control.
interface display_page_controller_if;
  import display_page_controller_pkg::*;

  logic                 frame_tick;
  logic                 video_on;
  logic                 sw_escape;
  logic [LEVEL_CNT-1:0] sw_level;
  logic                 level_pass;
  logic                 level_fail;
  logic [RGB_W-1:0]     rgb_start;
  logic [RGB_W-1:0]     rgb_level;
  logic [RGB_W-1:0]     rgb_result;
  logic [RGB_W-1:0]     rgb;
  logic [PAGE_W-1:0]    page;
  logic [LEVEL_W-1:0]   level;
  logic                 game_en;
  logic                 result_pass;

  modport master (
    output frame_tick, video_on, sw_escape, sw_level, level_pass, level_fail,
           rgb_start, rgb_level, rgb_result,
    input  rgb, page, level, game_en, result_pass
  );

  modport slave (
    input  frame_tick, video_on, sw_escape, sw_level, level_pass, level_fail,
           rgb_start, rgb_level, rgb_result,
    output rgb, page, level, game_en, result_pass
  );
endinterface

// File: rtl/switch_frame_debounce.sv
// Frame-rate switch debouncer: a value is accepted after SW_STABLE_FRAMES identical frame_tick samples.
// stable/accept are valid combinationally in the tick cycle itself; no backpressure.
module switch_frame_debounce #(
  parameter int WIDTH            = 4,
  parameter int SW_STABLE_FRAMES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             accept
);
  localparam int                CNT_W   = $clog2(SW_STABLE_FRAMES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SW_STABLE_FRAMES);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (frame_tick) begin
      if (raw != prev_q) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // The value accepted on this tick is exposed immediately so the FSM can act in the same tick.
  assign accept = frame_tick && (cnt_d == CNT_MAX);
  assign stable = accept ? raw : stable_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else if (frame_tick) begin
      prev_q <= raw;
      cnt_q  <= cnt_d;
      if (accept) stable_q <= raw;
    end
  end
endmodule

// File: rtl/display_page_controller.sv
// Screen sequencer: picks START/LEVEL/RESULT on frame boundaries, gates the game core, muxes page rgb.
// rgb, page, level, game_en, result_pass are registered (1 cycle); no backpressure.
module display_page_controller
  import display_page_controller_pkg::*;
#(
  parameter int SW_STABLE_FRAMES = 2,
  parameter int RESULT_FRAMES    = 180
) (
  input  logic                       clk,
  input  logic                       reset_n,
  display_page_controller_if.slave   bus
);
  localparam int               CNT_W       = $clog2(RESULT_FRAMES + 1);
  localparam logic [CNT_W-1:0] RESULT_LOAD = CNT_W'(RESULT_FRAMES);

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               pass_q, pass_d;
  logic               armed_q, armed_d;
  logic               game_en_q, game_en_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic               capture;
  sw_t                sw_stable;
  logic               sw_accept;

  switch_frame_debounce #(
    .WIDTH            (SW_W),
    .SW_STABLE_FRAMES (SW_STABLE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (bus.frame_tick),
    .raw        ({bus.sw_escape, bus.sw_level}),
    .stable     (sw_stable),
    .accept     (sw_accept)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pass_d  = pass_q;
    armed_d = armed_q;

    // First outcome pulse of a level wins; fail dominates a simultaneous pass.
    capture = (state_q == ST_LEVEL) && !pend_q && (bus.level_pass || bus.level_fail);
    if (capture) begin
      pend_d = 1'b1;
      pass_d = bus.level_pass && !bus.level_fail;
    end

    if (bus.frame_tick) begin
      case (state_q)
        ST_START: begin
          if (!sw_stable.esc && armed_q && (level_index(sw_stable.lvl) != '0)) begin
            state_d = ST_LEVEL;
            level_d = level_index(sw_stable.lvl);
          end
        end
        ST_LEVEL: begin
          if (sw_stable.esc) begin
            state_d = ST_START;
          end else if (pend_q) begin
            state_d = ST_RESULT;
            cnt_d   = RESULT_LOAD;
          end
        end
        ST_RESULT: begin
          if (sw_stable.esc || (cnt_q == CNT_W'(1))) begin
            state_d = ST_START;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_START;
      endcase
    end

    if (state_d == ST_START) level_d = '0;
    if (state_d != ST_LEVEL) pend_d = 1'b0;

    // Re-arm only after an all-clear switch value is accepted, so a still-raised switch cannot re-enter.
    if ((state_d == ST_START) && (state_q != ST_START)) begin
      armed_d = 1'b0;
    end else if (sw_accept && (sw_stable.lvl == '0)) begin
      armed_d = 1'b1;
    end

    game_en_d = (state_q == ST_LEVEL) && (state_d == ST_LEVEL) && !pend_q && !capture;

    rgb_d = '0;
    if (bus.video_on) begin
      case (state_q)
        ST_START:  rgb_d = bus.rgb_start;
        ST_LEVEL:  rgb_d = bus.rgb_level;
        ST_RESULT: rgb_d = bus.rgb_result;
        default:   rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_START;
      level_q   <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      pass_q    <= 1'b0;
      armed_q   <= 1'b0;
      game_en_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pass_q    <= pass_d;
      armed_q   <= armed_d;
      game_en_q <= game_en_d;
      rgb_q     <= rgb_d;
    end
  end

  assign bus.page        = state_q;
  assign bus.level       = level_q;
  assign bus.game_en     = game_en_q;
  assign bus.result_pass = pass_q;
  assign bus.rgb         = rgb_q;
endmodule

// File: tb/tb_display_page_controller.sv
// Bench for display_page_controller: directed scenarios plus randomized traffic against a queue-based model.
module tb_display_page_controller;
  import display_page_controller_pkg::*;

  localparam int SW_FRAMES   = 2;
  localparam int RES_FRAMES  = 4;
  localparam int FRAME_LEN   = 12;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;
  int   phase = 6;

  display_page_controller_if bus ();

  display_page_controller #(
    .SW_STABLE_FRAMES (SW_FRAMES),
    .RESULT_FRAMES    (RES_FRAMES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: outputs expected after the next clock edge.
  int          m_page, m_level, m_cnt;
  bit          m_game_en, m_pass, m_armed, m_pend;
  logic [11:0] m_rgb;
  logic [3:0]  m_stable;
  logic [3:0]  m_hist[$];

  function automatic void model_step();
    int pg;
    bit old_pend, cap, acc;
    logic [3:0] s;
    logic [2:0] lv;
    if (!reset_n) begin
      m_page = 0; m_level = 0; m_cnt = 0; m_game_en = 0; m_pass = 0;
      m_armed = 0; m_pend = 0; m_rgb = 0; m_stable = 0; m_hist.delete();
      return;
    end
    pg = m_page;
    old_pend = m_pend;
    acc = 0;
    s = {bus.sw_escape, bus.sw_level};
    m_rgb = !bus.video_on ? 12'h0 : (pg == 0) ? bus.rgb_start :
            (pg == 1) ? bus.rgb_level : (pg == 2) ? bus.rgb_result : 12'h0;
    cap = (pg == 1) && !old_pend && (bus.level_pass || bus.level_fail);
    if (cap) begin
      m_pend = 1;
      m_pass = bus.level_pass && !bus.level_fail;
    end
    if (bus.frame_tick) begin
      m_hist.push_back(s);
      if (m_hist.size() > SW_FRAMES) void'(m_hist.pop_front());
      acc = (m_hist.size() == SW_FRAMES);
      foreach (m_hist[i]) if (m_hist[i] != s) acc = 0;
      if (acc) m_stable = s;
      lv = m_stable[2:0];
      if (m_stable[3] && pg != 0) m_page = 0;
      else if (pg == 0 && !m_stable[3] && m_armed && $countones(lv) == 1) begin
        m_page = 1;
        m_level = (lv == 3'b001) ? 1 : (lv == 3'b010) ? 2 : 3;
      end else if (pg == 1 && old_pend) begin
        m_page = 2;
        m_cnt = RES_FRAMES;
      end else if (pg == 2) begin
        if (m_cnt == 1) m_page = 0;
        else m_cnt = m_cnt - 1;
      end
      if (m_page == 0) m_level = 0;
      if (pg != 0 && m_page == 0) m_armed = 0;
      else if (acc && s[2:0] == 3'b000) m_armed = 1;
    end
    if (m_page != 1) m_pend = 0;
    m_game_en = (pg == 1) && (m_page == 1) && !old_pend && !cap;
  endfunction

  // One clock: update model with current inputs, clock, then set next-cycle frame timing and pixels.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    phase = (phase + 1) % FRAME_LEN;
    bus.frame_tick = (phase == 0);
    bus.video_on   = (phase > 1) && ($urandom_range(0, 7) != 0);
    bus.rgb_start  = 12'($urandom);
    bus.rgb_level  = 12'($urandom);
    bus.rgb_result = 12'($urandom);
  endtask

  task automatic run_ticks(input int n);
    int k = 0;
    for (int c = 0; c < (n + 1) * FRAME_LEN && k < n; c++) begin
      if (bus.frame_tick) k++;
      cycle();
    end
  endtask

  task automatic set_sw(input logic esc, input logic [2:0] lvl);
    bus.sw_escape = esc;
    bus.sw_level  = lvl;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_sw(1'b0, 3'b010);
    for (int i = 0; i < 3; i++) cycle();
    checks += 5;
    if (bus.rgb !== 12'h0) begin failures++; $display("FAIL reset_rgb: got %0h expected 0", bus.rgb); end
    if (bus.page !== 2'd0) begin failures++; $display("FAIL reset_page: got %0d expected 0", bus.page); end
    if (bus.level !== 2'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
    if (bus.game_en !== 1'b0) begin failures++; $display("FAIL reset_game_en: got %0b expected 0", bus.game_en); end
    if (bus.result_pass !== 1'b0) begin failures++; $display("FAIL reset_result_pass: got %0b expected 0", bus.result_pass); end
    reset_n = 1'b1;
    run_ticks(4);
    checks++;
    if (bus.page !== 2'd0) begin failures++; $display("FAIL reset_unarmed_page: got %0d expected 0", bus.page); end
    set_sw(1'b0, 3'b000);
    run_ticks(3);
    checks++;
    if (bus.page !== 2'd0) begin failures++; $display("FAIL reset_cleared_page: got %0d expected 0", bus.page); end
  endtask

  task automatic test_entry();
    logic [11:0] px;
    set_sw(1'b0, 3'b010);
    run_ticks(1);
    checks++;
    if (bus.page !== 2'd0) begin failures++; $display("FAIL entry_early_page: got %0d expected 0", bus.page); end
    run_ticks(1);
    checks += 3;
    if (bus.page !== 2'd1) begin failures++; $display("FAIL entry_page: got %0d expected 1", bus.page); end
    if (bus.level !== 2'd2) begin failures++; $display("FAIL entry_level: got %0d expected 2", bus.level); end
    if (bus.game_en !== 1'b0) begin failures++; $display("FAIL entry_game_en_lag: got %0b expected 0", bus.game_en); end
    cycle();
    checks++;
    if (bus.game_en !== 1'b1) begin failures++; $display("FAIL entry_game_en: got %0b expected 1", bus.game_en); end
    bus.video_on = 1'b1;
    px = bus.rgb_level;
    cycle();
    checks++;
    if (bus.rgb !== px) begin failures++; $display("FAIL entry_rgb: got %0h expected %0h", bus.rgb, px); end
  endtask

  task automatic test_result();
    for (int i = 0; i < 3; i++) cycle();
    if (bus.frame_tick) cycle();
    bus.level_pass = 1'b1;
    bus.level_fail = 1'b1;
    cycle();
    bus.level_pass = 1'b0;
    bus.level_fail = 1'b0;
    checks += 2;
    if (bus.game_en !== 1'b0) begin failures++; $display("FAIL result_game_en: got %0b expected 0", bus.game_en); end
    if (bus.page !== 2'd1) begin failures++; $display("FAIL result_page_hold: got %0d expected 1", bus.page); end
    run_ticks(1);
    checks += 2;
    if (bus.page !== 2'd2) begin failures++; $display("FAIL result_page: got %0d expected 2", bus.page); end
    if (bus.result_pass !== 1'b0) begin failures++; $display("FAIL result_fail_wins: got %0b expected 0", bus.result_pass); end
    run_ticks(3);
    checks++;
    if (bus.page !== 2'd2) begin failures++; $display("FAIL result_hold: got %0d expected 2", bus.page); end
    run_ticks(1);
    checks += 2;
    if (bus.page !== 2'd0) begin failures++; $display("FAIL result_exit_page: got %0d expected 0", bus.page); end
    if (bus.level !== 2'd0) begin failures++; $display("FAIL result_exit_level: got %0d expected 0", bus.level); end
    run_ticks(3);
    checks++;
    if (bus.page !== 2'd0) begin failures++; $display("FAIL result_no_reentry: got %0d expected 0", bus.page); end
  endtask

  task automatic test_glitch();
    set_sw(1'b0, 3'b000);
    run_ticks(3);
    set_sw(1'b0, 3'b001);
    run_ticks(1);
    set_sw(1'b0, 3'b000);
    run_ticks(3);
    checks++;
    if (bus.page !== 2'd0) begin failures++; $display("FAIL glitch_page: got %0d expected 0", bus.page); end
    set_sw(1'b0, 3'b011);
    run_ticks(5);
    checks++;
    if (bus.page !== 2'd0) begin failures++; $display("FAIL invalid_page: got %0d expected 0", bus.page); end
    set_sw(1'b0, 3'b000);
    run_ticks(3);
  endtask

  task automatic test_escape();
    set_sw(1'b0, 3'b001);
    run_ticks(2);
    checks += 2;
    if (bus.page !== 2'd1) begin failures++; $display("FAIL escape_enter_page: got %0d expected 1", bus.page); end
    if (bus.level !== 2'd1) begin failures++; $display("FAIL escape_enter_level: got %0d expected 1", bus.level); end
    set_sw(1'b1, 3'b001);
    run_ticks(2);
    checks += 3;
    if (bus.page !== 2'd0) begin failures++; $display("FAIL escape_page: got %0d expected 0", bus.page); end
    if (bus.level !== 2'd0) begin failures++; $display("FAIL escape_level: got %0d expected 0", bus.level); end
    if (bus.game_en !== 1'b0) begin failures++; $display("FAIL escape_game_en: got %0b expected 0", bus.game_en); end
    set_sw(1'b0, 3'b000);
    run_ticks(3);
    set_sw(1'b0, 3'b100);
    run_ticks(2);
    checks += 2;
    if (bus.page !== 2'd1) begin failures++; $display("FAIL escape_reenter_page: got %0d expected 1", bus.page); end
    if (bus.level !== 2'd3) begin failures++; $display("FAIL escape_reenter_level: got %0d expected 3", bus.level); end
  endtask

  task automatic test_coincident();
    for (int c = 0; c < FRAME_LEN && !bus.frame_tick; c++) cycle();
    bus.level_pass = 1'b1;
    cycle();
    bus.level_pass = 1'b0;
    checks += 3;
    if (bus.page !== 2'd1) begin failures++; $display("FAIL coinc_page_hold: got %0d expected 1", bus.page); end
    if (bus.game_en !== 1'b0) begin failures++; $display("FAIL coinc_game_en: got %0b expected 0", bus.game_en); end
    if (bus.result_pass !== 1'b1) begin failures++; $display("FAIL coinc_result_pass: got %0b expected 1", bus.result_pass); end
    run_ticks(1);
    checks++;
    if (bus.page !== 2'd2) begin failures++; $display("FAIL coinc_page: got %0d expected 2", bus.page); end
    run_ticks(4);
    checks++;
    if (bus.page !== 2'd0) begin failures++; $display("FAIL coinc_exit: got %0d expected 0", bus.page); end
  endtask

  task automatic test_rgb();
    logic [1:0] pg;
    bit tk, vo;
    for (int i = 0; i < 3 * FRAME_LEN; i++) begin
      pg = bus.page;
      tk = bus.frame_tick;
      vo = bus.video_on;
      cycle();
      checks++;
      if (!vo && bus.rgb !== 12'h0) begin failures++; $display("FAIL rgb_blank: got %0h expected 0", bus.rgb); end
      checks++;
      if (!tk && bus.page !== pg) begin failures++; $display("FAIL page_midframe: got %0d expected %0d", bus.page, pg); end
      checks++;
      if (bus.rgb !== m_rgb) begin failures++; $display("FAIL rgb_model: got %0h expected %0h", bus.rgb, m_rgb); end
    end
  endtask

  task automatic test_random();
    logic [1:0] pg;
    bit tk;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 7))
          3:       set_sw(1'b0, 3'b001);
          4:       set_sw(1'b0, 3'b010);
          5:       set_sw(1'b0, 3'b100);
          6:       set_sw(1'b1, 3'b000);
          7:       set_sw(1'($urandom), 3'($urandom));
          default: set_sw(1'b0, 3'b000);
        endcase
      end
      bus.level_pass = ($urandom_range(0, 29) == 0);
      bus.level_fail = ($urandom_range(0, 39) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      pg = bus.page;
      tk = bus.frame_tick;
      cycle();
      reset_n = 1'b1;
      bus.level_pass = 1'b0;
      bus.level_fail = 1'b0;
      checks += 6;
      if (bus.page !== 2'(m_page)) begin failures++; $display("FAIL rand_page: got %0d expected %0d", bus.page, m_page); end
      if (bus.level !== 2'(m_level)) begin failures++; $display("FAIL rand_level: got %0d expected %0d", bus.level, m_level); end
      if (bus.game_en !== m_game_en) begin failures++; $display("FAIL rand_game_en: got %0b expected %0b", bus.game_en, m_game_en); end
      if (bus.result_pass !== m_pass) begin failures++; $display("FAIL rand_result_pass: got %0b expected %0b", bus.result_pass, m_pass); end
      if (bus.rgb !== m_rgb) begin failures++; $display("FAIL rand_rgb: got %0h expected %0h", bus.rgb, m_rgb); end
      if (!tk && reset_n && pg != 2'd0 && bus.page !== pg && m_page == int'(pg)) begin
        failures++; $display("FAIL rand_page_midframe: got %0d expected %0d", bus.page, pg);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_sw(1'b0, 3'b000);
    run_ticks(3);
    set_sw(1'b0, 3'b010);
    run_ticks(2);
    for (int i = 0; i < 4; i++) cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    checks += 4;
    if (bus.page !== 2'd0) begin failures++; $display("FAIL midreset_page: got %0d expected 0", bus.page); end
    if (bus.level !== 2'd0) begin failures++; $display("FAIL midreset_level: got %0d expected 0", bus.level); end
    if (bus.game_en !== 1'b0) begin failures++; $display("FAIL midreset_game_en: got %0b expected 0", bus.game_en); end
    if (bus.rgb !== 12'h0) begin failures++; $display("FAIL midreset_rgb: got %0h expected 0", bus.rgb); end
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.frame_tick = 1'b0;
    bus.video_on   = 1'b0;
    bus.sw_escape  = 1'b0;
    bus.sw_level   = 3'b000;
    bus.level_pass = 1'b0;
    bus.level_fail = 1'b0;
    bus.rgb_start  = 12'h0;
    bus.rgb_level  = 12'h0;
    bus.rgb_result = 12'h0;
    test_reset();
    test_entry();
    test_result();
    test_glitch();
    test_escape();
    test_coincident();
    test_rgb();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
